dma_block_copy: RTL and testbench

Memory-to-memory DMA engine on the shared RAM bus of the microprocessor. On a CPU start command it copies a block of 10-bit words from a source region of data RAM to a destination region. It requests the bus through the existing two-master arbiter (req/grant) and drives the RAM port only while granted. It runs alongside the CPU/cache side of the memory module and reports its state so that benches can stop on completion.

---
 rtl/dma_block_copy_if.sv | 35 +++
 rtl/dma_block_copy.sv | 151 +++++++++++++++
 tb/tb_dma_block_copy.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dma_block_copy_if.sv
// Bus bundle for the block-copy DMA: CPU command side plus the shared RAM port.
// The master modport is the DMA engine; the slave modport is the CPU/RAM/arbiter side.
interface dma_block_copy_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 6
);
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic              req;
  logic              grant;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_read;
  logic              ram_write;
  logic [DATA_W-1:0] ram_outdata;
  logic [DATA_W-1:0] ram_indata;
  logic [2:0]        dma_state;
  logic [LEN_W-1:0]  word_cnt;

  modport master (
    input  start, src_addr, dst_addr, length, grant, ram_outdata,
    output busy, done, req, ram_addr, ram_read, ram_write, ram_indata,
           dma_state, word_cnt
  );

  modport slave (
    output start, src_addr, dst_addr, length, grant, ram_outdata,
    input  busy, done, req, ram_addr, ram_read, ram_write, ram_indata,
           dma_state, word_cnt
  );
endinterface

// File: rtl/dma_block_copy.sv
// Memory-to-memory block copy engine on the arbitrated RAM bus.
// Each word is RD -> CAP -> WR; grant is only re-examined at word boundaries.
module dma_block_copy #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 6
) (
  input logic            clk,
  input logic            rst,
  dma_block_copy_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] src_q,       src_d;
  logic [ADDR_W-1:0] dst_q,       dst_d;
  logic [LEN_W-1:0]  len_q,       len_d;
  logic [LEN_W-1:0]  word_cnt_q,  word_cnt_d;
  logic [DATA_W-1:0] buf_q,       buf_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0] ram_indata_q, ram_indata_d;
  logic              ram_read_q,  ram_read_d;
  logic              ram_write_q, ram_write_d;
  logic              req_q,       req_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic [LEN_W-1:0]  cnt_inc_s;

  assign cnt_inc_s = word_cnt_q + LEN_W'(1);

  // Next state, latched parameters, and the outputs the next state will present.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    buf_d      = buf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          src_d      = bus.src_addr;
          dst_d      = bus.dst_addr;
          len_d      = bus.length;
          word_cnt_d = {LEN_W{1'b0}};
          if (bus.length == {LEN_W{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.grant) begin
          state_d = S_RD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        buf_d   = bus.ram_outdata;
        state_d = S_WR;
      end
      S_WR: begin
        word_cnt_d = cnt_inc_s;
        if (cnt_inc_s == len_q) begin
          state_d = S_DONE;
        end else if (bus.grant) begin
          state_d = S_RD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    req_d       = (state_d == S_REQ) || (state_d == S_RD) ||
                  (state_d == S_CAP) || (state_d == S_WR);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    ram_read_d  = (state_d == S_RD);
    ram_write_d = (state_d == S_WR);
    case (state_d)
      S_RD:    ram_addr_d = src_d + ADDR_W'(word_cnt_d);
      S_WR:    ram_addr_d = dst_d + ADDR_W'(word_cnt_d);
      default: ram_addr_d = {ADDR_W{1'b0}};
    endcase
    if (state_d == S_WR) begin
      ram_indata_d = buf_d;
    end else begin
      ram_indata_d = {DATA_W{1'b0}};
    end
  end

  // State and registered outputs; async reset kills an in-flight write at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      src_q        <= {ADDR_W{1'b0}};
      dst_q        <= {ADDR_W{1'b0}};
      len_q        <= {LEN_W{1'b0}};
      word_cnt_q   <= {LEN_W{1'b0}};
      buf_q        <= {DATA_W{1'b0}};
      ram_addr_q   <= {ADDR_W{1'b0}};
      ram_indata_q <= {DATA_W{1'b0}};
      ram_read_q   <= 1'b0;
      ram_write_q  <= 1'b0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      buf_q        <= buf_d;
      ram_addr_q   <= ram_addr_d;
      ram_indata_q <= ram_indata_d;
      ram_read_q   <= ram_read_d;
      ram_write_q  <= ram_write_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.req        = req_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_read   = ram_read_q;
  assign bus.ram_write  = ram_write_q;
  assign bus.ram_indata = ram_indata_q;
  assign bus.dma_state  = state_q;
  assign bus.word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_dma_block_copy.sv
// Directed bench for dma_block_copy with a behavioural one-cycle-latency RAM.
module tb_dma_block_copy;
  localparam int DATA_W = 10;
  localparam int ADDR_W = 14;
  localparam int LEN_W  = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dma_block_copy_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  dma_block_copy #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_W-1:0] mem [0:16383];
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] rd_log [$];
  logic [ADDR_W-1:0] wr_log [$];

  // RAM model: read data appears the cycle after ram_read is sampled.
  always @(posedge clk) begin
    if (bus.ram_read) begin
      rd_q <= mem[bus.ram_addr];
      rd_log.push_back(bus.ram_addr);
    end
    if (bus.ram_write) begin
      mem[bus.ram_addr] <= bus.ram_indata;
      wr_log.push_back(bus.ram_addr);
    end
  end
  assign bus.ram_outdata = rd_q;

  int total = 0;
  int bad   = 0;
  int done_at, done_cnt, busy_cycles;
  bit req_seen, rd_seen, wr_seen;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // md: 0 plain, 1 drop grant in CAP of word 1, 2 re-pulse start while busy.
  task automatic run_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input logic [LEN_W-1:0] l, input int md);
    int n;
    int low_cnt;
    bit dropped;
    done_at = 0; done_cnt = 0; busy_cycles = 0;
    req_seen = 1'b0; rd_seen = 1'b0; wr_seen = 1'b0;
    rd_log.delete();
    wr_log.delete();
    bus.src_addr = s; bus.dst_addr = d; bus.length = l; bus.start = 1'b1;
    n = 0; low_cnt = 0; dropped = 1'b0;
    while (done_cnt == 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
      bus.start = 1'b0;
      if (md == 2 && n == 5) begin
        bus.start = 1'b1;
        bus.src_addr = 14'h0200; bus.dst_addr = 14'h0300; bus.length = 6'd2;
      end
      if (bus.busy) busy_cycles++;
      if (bus.req) req_seen = 1'b1;
      if (bus.ram_read) rd_seen = 1'b1;
      if (bus.ram_write) wr_seen = 1'b1;
      if (bus.done) begin done_cnt++; done_at = n; end
      if (md == 1) begin
        if (!dropped && bus.dma_state == 3'd3 && bus.word_cnt == 6'd1) begin
          bus.grant = 1'b0;
          dropped = 1'b1;
        end else if (dropped && !bus.grant) begin
          low_cnt++;
          if (low_cnt == 1) check_val("gdrop_word1_write", {bus.dma_state, bus.ram_write}, {3'd4, 1'b1});
          if (low_cnt == 2) check_val("gdrop_back_in_req",
                                      {bus.dma_state, bus.req, bus.ram_read, bus.ram_write},
                                      {3'd1, 1'b1, 1'b0, 1'b0});
          if (low_cnt == 4) bus.grant = 1'b1;
        end
      end
    end
    bus.grant = 1'b1;
    @(posedge clk); #1;
    if (bus.done) done_cnt++;
    check_val("idle_after_done", {bus.busy, bus.done, bus.dma_state}, {1'b0, 1'b0, 3'd0});
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 10'd0;
    rd_q = 10'd0;
    bus.start = 1'b0; bus.grant = 1'b1;
    bus.src_addr = 14'd0; bus.dst_addr = 14'd0; bus.length = 6'd0;
    #12;
    check_val("reset_outputs",
              {bus.busy, bus.done, bus.req, bus.ram_read, bus.ram_write, bus.dma_state},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
    check_val("reset_addr_cnt", {bus.ram_addr, bus.ram_indata, bus.word_cnt}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Basic 4-word copy with grant tied high.
    mem[14'h10] = 10'd5; mem[14'h11] = 10'd10; mem[14'h12] = 10'd15; mem[14'h13] = 10'd1023;
    run_copy(14'h0010, 14'h0100, 6'd4, 0);
    check_val("basic_done_cycle", done_at, 14);
    check_val("basic_done_once", done_cnt, 1);
    check_val("basic_dst0", mem[14'h100], 10'd5);
    check_val("basic_dst1", mem[14'h101], 10'd10);
    check_val("basic_dst2", mem[14'h102], 10'd15);
    check_val("basic_dst3", mem[14'h103], 10'd1023);
    check_val("basic_src_kept", {mem[14'h10], mem[14'h11], mem[14'h12], mem[14'h13]},
              {10'd5, 10'd10, 10'd15, 10'd1023});
    check_val("basic_word_cnt", bus.word_cnt, 6'd4);

    // Zero-length request.
    run_copy(14'h0500, 14'h0600, 6'd0, 0);
    check_val("zero_done_cycle", done_at, 1);
    check_val("zero_no_bus", {req_seen, rd_seen, wr_seen}, 3'b000);
    check_val("zero_busy_cycles", busy_cycles, 1);
    check_val("zero_no_access", rd_log.size() + wr_log.size(), 0);

    // Address wrap with overlapping forward copy.
    mem[14'h3FFE] = 10'd100; mem[14'h3FFF] = 10'd200; mem[14'h0000] = 10'd300;
    run_copy(14'h3FFE, 14'h3FFF, 6'd3, 0);
    check_val("wrap_rd_count", rd_log.size(), 3);
    check_val("wrap_wr_count", wr_log.size(), 3);
    if (rd_log.size() == 3 && wr_log.size() == 3) begin
      check_val("wrap_rd_addrs", {rd_log[0], rd_log[1], rd_log[2]}, {14'h3FFE, 14'h3FFF, 14'h0000});
      check_val("wrap_wr_addrs", {wr_log[0], wr_log[1], wr_log[2]}, {14'h3FFF, 14'h0000, 14'h0001});
    end
    check_val("wrap_data", {mem[14'h3FFF], mem[14'h0000], mem[14'h0001]},
              {10'd100, 10'd100, 10'd100});

    // Grant withdrawn during CAP of word 1.
    mem[14'h20] = 10'd7; mem[14'h21] = 10'd300; mem[14'h22] = 10'd512;
    run_copy(14'h0020, 14'h0120, 6'd3, 1);
    check_val("gdrop_done_once", done_cnt, 1);
    check_val("gdrop_data", {mem[14'h120], mem[14'h121], mem[14'h122]},
              {10'd7, 10'd300, 10'd512});
    check_val("gdrop_wr_count", wr_log.size(), 3);

    // Start re-pulsed while busy must be ignored.
    mem[14'h30] = 10'd11; mem[14'h31] = 10'd22; mem[14'h32] = 10'd33;
    mem[14'h200] = 10'd44; mem[14'h201] = 10'd55;
    run_copy(14'h0030, 14'h0140, 6'd3, 2);
    check_val("restart_done_cycle", done_at, 11);
    check_val("restart_data", {mem[14'h140], mem[14'h141], mem[14'h142]},
              {10'd11, 10'd22, 10'd33});
    check_val("restart_other_untouched", {mem[14'h300], mem[14'h301]}, 20'd0);
    check_val("restart_word_cnt", bus.word_cnt, 6'd3);

    // Asynchronous reset during WR of word 2.
    for (int i = 0; i < 4; i++) begin
      mem[14'h40 + i] = 10'(i + 20);
      mem[14'h80 + i] = 10'h2AA;
    end
    bus.src_addr = 14'h0040; bus.dst_addr = 14'h0080; bus.length = 6'd4; bus.start = 1'b1;
    begin
      int n;
      n = 0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (!(bus.dma_state == 3'd4 && bus.word_cnt == 6'd2) && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check_val("rst_reached_wr2", n < 100, 1'b1);
    end
    #1 rst = 1'b0;
    #1;
    check_val("rst_outputs_cleared",
              {bus.busy, bus.done, bus.req, bus.ram_read, bus.ram_write, bus.dma_state},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
    check_val("rst_addr_cleared", {bus.ram_addr, bus.ram_indata, bus.word_cnt}, 32'd0);
    #4 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("rst_words_before", {mem[14'h80], mem[14'h81]}, {10'd20, 10'd21});
    check_val("rst_word2_not_written", {mem[14'h82], mem[14'h83]}, {10'h2AA, 10'h2AA});
    check_val("rst_stays_idle", {bus.busy, bus.dma_state}, {1'b0, 3'd0});

    run_copy(14'h0040, 14'h0080, 6'd4, 0);
    check_val("rst_fresh_done_cycle", done_at, 14);
    check_val("rst_fresh_data", {mem[14'h80], mem[14'h81], mem[14'h82], mem[14'h83]},
              {10'd20, 10'd21, 10'd22, 10'd23});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
